// File: rtl/tcdm_apb_pkg.sv
// Shared types for the TCDM-to-APB responder: FSM states, the latched request
// and the default error read value.
package tcdm_apb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } state_e;

    // Address is held at the widest supported TCDM width; the top narrows it for paddr.
    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
        logic [3:0]  be;
    } tcdm_req_t;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADC_AB1E;

endpackage

// File: rtl/tcdm_apb_timeout_cnt.sv
// Saturating ACCESS-cycle counter; expire_o flags the last permitted cycle.
// A TIMEOUT_CYCLES of 0 disables expiry entirely.
module tcdm_apb_timeout_cnt #(
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expire_o
);

    localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= sat_inc(cnt_q);
        end
    end

    assign expire_o = (TIMEOUT_CYCLES != 0) && en_i && (cnt_q == LIMIT);

endmodule

// File: rtl/tcdm_apb_responder.sv
// Bridges one TCDM request/grant/r_valid transaction at a time onto APB4,
// answering out-of-window or timed-out accesses with an error response.
module tcdm_apb_responder
    import tcdm_apb_pkg::*;
#(
    parameter int          ADDR_WIDTH     = 32,
    parameter int          DATA_WIDTH     = 32,
    parameter int          APB_ADDR_WIDTH = 32,
    parameter logic [31:0] WIN_BASE       = 32'h1A10_0000,
    parameter logic [31:0] WIN_SIZE       = 32'h0010_0000,
    parameter int unsigned TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_i,
    input  logic [ADDR_WIDTH-1:0]     add_i,
    input  logic                      wen_i,
    input  logic [31:0]               wdata_i,
    input  logic [3:0]                be_i,
    output logic                      gnt_o,
    output logic                      r_valid_o,
    output logic [31:0]               r_rdata_o,
    output logic                      r_opc_o,
    output logic [APB_ADDR_WIDTH-1:0] paddr_o,
    output logic [31:0]               pwdata_o,
    output logic                      pwrite_o,
    output logic [3:0]                pstrb_o,
    output logic                      psel_o,
    output logic                      penable_o,
    input  logic [31:0]               prdata_i,
    input  logic                      pready_i,
    input  logic                      pslverr_i
);

    state_e          state_q, state_d;
    tcdm_req_t       req_q;
    logic [ADDR_WIDTH-1:0] win_off;
    logic            in_win;
    logic            expire;

    // Unsigned offset compare: addresses below WIN_BASE wrap to large offsets.
    assign win_off = add_i - ADDR_WIDTH'(WIN_BASE);
    assign in_win  = win_off < ADDR_WIDTH'(WIN_SIZE);
    assign gnt_o   = req_i & ((state_q == IDLE) | (state_q == RESP));

    tcdm_apb_timeout_cnt #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (state_q == SETUP),
        .en_i    (state_q == ACCESS),
        .expire_o(expire)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_i) state_d = in_win ? SETUP : RESP;
            SETUP:   state_d = ACCESS;
            ACCESS:  if (pready_i || expire) state_d = RESP;
            RESP:    if (req_i) state_d = in_win ? SETUP : RESP;
                     else       state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // APB strobes come straight from state so reset drops them asynchronously.
    always_comb begin
        psel_o    = 1'b0;
        penable_o = 1'b0;
        r_valid_o = 1'b0;
        case (state_q)
            SETUP:   psel_o = 1'b1;
            ACCESS:  begin psel_o = 1'b1; penable_o = 1'b1; end
            RESP:    r_valid_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            req_q     <= '0;
            r_rdata_o <= '0;
            r_opc_o   <= 1'b0;
        end else begin
            if (gnt_o) begin
                req_q.addr  <= 32'(add_i);
                req_q.write <= ~wen_i;
                req_q.wdata <= wdata_i;
                req_q.be    <= be_i;
                if (!in_win) begin
                    r_rdata_o <= ERR_RDATA;
                    r_opc_o   <= 1'b1;
                end
            end else if (state_q == ACCESS && pready_i) begin
                r_rdata_o <= req_q.write ? 32'h0 : prdata_i;
                r_opc_o   <= pslverr_i;
            end else if (state_q == ACCESS && expire) begin
                r_rdata_o <= ERR_RDATA;
                r_opc_o   <= 1'b1;
            end
        end
    end

    assign paddr_o  = APB_ADDR_WIDTH'(req_q.addr);
    assign pwdata_o = req_q.wdata;
    assign pwrite_o = req_q.write;
    assign pstrb_o  = req_q.write ? req_q.be : 4'b0000;

endmodule
